// File: rtl/vga_timing_gen.sv
// Raster timing generator for 1280x720@60: counters, syncs, blanking.
// Optional frame counter output enabled by VGA_TIMING_FRAME_CNT_EN.
module vga_timing_gen #(
  parameter int H_ACTIVE     = 1280,
  parameter int H_TOTAL      = 1650,
  parameter int H_SYNC_START = 1390,
  parameter int H_SYNC_W     = 40,
  parameter int V_ACTIVE     = 720,
  parameter int V_TOTAL      = 750,
  parameter int V_SYNC_START = 725,
  parameter int V_SYNC_W     = 5
) (
  input  logic        pclk,
  input  logic        rst_n,
  input  logic        ce,
  output logic [10:0] hcount,
  output logic        hsync,
  output logic        hblnk,
  output logic [10:0] vcount,
  output logic        vsync,
  output logic        vblnk,
  output logic        frame_start
`ifdef VGA_TIMING_FRAME_CNT_EN
  ,
  output logic [15:0] frame_cnt
`endif
);

  localparam logic [10:0] H_MAX = 11'(H_TOTAL - 1);
  localparam logic [10:0] V_MAX = 11'(V_TOTAL - 1);
  localparam logic [10:0] H_ACT = 11'(H_ACTIVE);
  localparam logic [10:0] V_ACT = 11'(V_ACTIVE);
  localparam logic [10:0] H_SS  = 11'(H_SYNC_START);
  localparam logic [10:0] H_SE  = 11'(H_SYNC_START + H_SYNC_W);
  localparam logic [10:0] V_SS  = 11'(V_SYNC_START);
  localparam logic [10:0] V_SE  = 11'(V_SYNC_START + V_SYNC_W);

  logic        h_end;
  logic        v_end;
  logic        wrap;
  logic [10:0] hcount_nx;
  logic [10:0] vcount_nx;
  logic        hsync_nx;
  logic        hblnk_nx;
  logic        vsync_nx;
  logic        vblnk_nx;

  // Next position and flags decoded from it, so flags land with counters.
  always_comb begin
    h_end     = (hcount == H_MAX);
    v_end     = (vcount == V_MAX);
    wrap      = h_end && v_end;
    hcount_nx = h_end ? 11'd0 : hcount + 11'd1;
    vcount_nx = vcount;
    if (h_end) begin
      vcount_nx = v_end ? 11'd0 : vcount + 11'd1;
    end
    hblnk_nx = (hcount_nx >= H_ACT);
    vblnk_nx = (vcount_nx >= V_ACT);
    hsync_nx = (hcount_nx >= H_SS) && (hcount_nx < H_SE);
    vsync_nx = (vcount_nx >= V_SS) && (vcount_nx < V_SE);
  end

  // Position and flag registers; frame_start is a single-edge pulse.
  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      hcount      <= '0;
      vcount      <= '0;
      hsync       <= 1'b0;
      hblnk       <= 1'b0;
      vsync       <= 1'b0;
      vblnk       <= 1'b0;
      frame_start <= 1'b0;
    end else if (ce) begin
      hcount      <= hcount_nx;
      vcount      <= vcount_nx;
      hsync       <= hsync_nx;
      hblnk       <= hblnk_nx;
      vsync       <= vsync_nx;
      vblnk       <= vblnk_nx;
      frame_start <= wrap;
    end else begin
      frame_start <= 1'b0;
    end
  end

`ifdef VGA_TIMING_FRAME_CNT_EN
  // Frame counter advances on the same edge that raises frame_start.
  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      frame_cnt <= '0;
    end else if (ce && wrap) begin
      frame_cnt <= frame_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// Randomized bench for vga_timing_gen against an arithmetic raster model.
// Runs a full-size instance and a small-raster instance side by side.
module tb_vga_timing_gen;

  localparam int SHA = 12;
  localparam int SHT = 20;
  localparam int SHS = 14;
  localparam int SHW = 3;
  localparam int SVA = 6;
  localparam int SVT = 10;
  localparam int SVS = 7;
  localparam int SVW = 2;

  logic pclk = 1'b0;
  logic rst_n = 1'b0;
  logic ce = 1'b0;

  logic [10:0] hc_d, vc_d, hc_s, vc_s;
  logic hs_d, hb_d, vs_d, vb_d, fs_d;
  logic hs_s, hb_s, vs_s, vb_s, fs_s;
  logic [15:0] fc_d, fc_s;

  int n_chk = 0;
  int n_fail = 0;
  int p_d = 0;
  int p_s = 0;
  bit last_en = 1'b0;

  always #5 pclk = ~pclk;

  vga_timing_gen u_dut (
    .pclk(pclk), .rst_n(rst_n), .ce(ce),
    .hcount(hc_d), .hsync(hs_d), .hblnk(hb_d),
    .vcount(vc_d), .vsync(vs_d), .vblnk(vb_d),
    .frame_start(fs_d)
`ifdef VGA_TIMING_FRAME_CNT_EN
    , .frame_cnt(fc_d)
`endif
  );

  vga_timing_gen #(
    .H_ACTIVE(SHA), .H_TOTAL(SHT),
    .H_SYNC_START(SHS), .H_SYNC_W(SHW),
    .V_ACTIVE(SVA), .V_TOTAL(SVT),
    .V_SYNC_START(SVS), .V_SYNC_W(SVW)
  ) u_small (
    .pclk(pclk), .rst_n(rst_n), .ce(ce),
    .hcount(hc_s), .hsync(hs_s), .hblnk(hb_s),
    .vcount(vc_s), .vsync(vs_s), .vblnk(vb_s),
    .frame_start(fs_s)
`ifdef VGA_TIMING_FRAME_CNT_EN
    , .frame_cnt(fc_s)
`endif
  );

`ifndef VGA_TIMING_FRAME_CNT_EN
  assign fc_d = 16'd0;
  assign fc_s = 16'd0;
`endif

  task automatic chk(string tag, logic [63:0] got, logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Position p = enabled edges since reset; everything follows by arithmetic.
  function automatic logic [63:0] model(
    int p, bit en, int ha, int ht, int hs, int hw,
    int va, int vt, int vs, int vw);
    int h, v, fr;
    logic fs;
    logic [15:0] fc;
    h  = p % ht;
    v  = (p / ht) % vt;
    fr = p / (ht * vt);
    fs = en && (p > 0) && ((p % (ht * vt)) == 0);
`ifdef VGA_TIMING_FRAME_CNT_EN
    fc = 16'(fr);
`else
    fc = 16'd0;
`endif
    return {21'd0, fc, 11'(h), 11'(v),
            (h >= hs) && (h < hs + hw), h >= ha,
            (v >= vs) && (v < vs + vw), v >= va, fs};
  endfunction

  function automatic logic [63:0] obs_d();
    return {21'd0, fc_d, hc_d, vc_d, hs_d, hb_d, vs_d, vb_d, fs_d};
  endfunction

  function automatic logic [63:0] obs_s();
    return {21'd0, fc_s, hc_s, vc_s, hs_s, hb_s, vs_s, vb_s, fs_s};
  endfunction

  task automatic check_all();
    chk("dflt", obs_d(),
        model(p_d, last_en, 1280, 1650, 1390, 40, 720, 750, 725, 5));
    chk("small", obs_s(),
        model(p_s, last_en, SHA, SHT, SHS, SHW, SVA, SVT, SVS, SVW));
  endtask

  // One clock with the given enable, then sample on the falling edge.
  task automatic step(bit c);
    ce = c;
    @(posedge pclk);
    if (c) begin
      p_d++;
      p_s++;
    end
    last_en = c;
    @(negedge pclk);
    check_all();
  endtask

  initial begin
    int guard;
    #1;
    chk("rst_dflt", obs_d(), 64'd0);
    chk("rst_small", obs_s(), 64'd0);
    @(negedge pclk);
    @(negedge pclk);
    rst_n = 1'b1;

    step(1'b1);
    chk("first_h", 64'(hc_d), 64'd1);
    chk("first_v", 64'(vc_d), 64'd0);

    for (int i = 0; i < 3400; i++) step(1'b1);

    guard = 0;
    while (hc_d != 11'd1389 && guard < 2000) begin
      step(1'b1);
      guard++;
    end
    chk("seek_1389", 64'(hc_d), 64'd1389);
    for (int i = 0; i < 7; i++) begin
      step(1'b0);
      chk("hold_h", 64'(hc_d), 64'd1389);
      chk("hold_hs", 64'(hs_d), 64'd0);
    end
    step(1'b1);
    chk("resume_h", 64'(hc_d), 64'd1390);
    chk("resume_hs", 64'(hs_d), 64'd1);

    for (int i = 0; i < 20000; i++) begin
      step(($urandom_range(0, 3) != 0) ? 1'b1 : 1'b0);
    end

    #3;
    rst_n = 1'b0;
    #1;
    chk("arst_dflt", obs_d(), 64'd0);
    chk("arst_small", obs_s(), 64'd0);
    p_d = 0;
    p_s = 0;
    last_en = 1'b0;
    @(negedge pclk);
    chk("arst_hold", obs_d(), 64'd0);
    rst_n = 1'b1;
    step(1'b1);
    chk("restart_h", 64'(hc_d), 64'd1);
    chk("restart_v", 64'(vc_d), 64'd0);

    for (int i = 0; i < 3000; i++) begin
      step(($urandom_range(0, 7) != 0) ? 1'b1 : 1'b0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
